// File: rtl/biriscv_inst_queue_pkg.sv
// biriscv_inst_queue_pkg: shared entry layout and push-side helpers for the instruction queue
package biriscv_inst_queue_pkg;

    // Full entry: 64b instr, pc[31:2], 2b pred, 2b faults, 2b slot_v.
    localparam int ENTRY_W         = 100;
    // slot_v lives beside the RAM, so the array only holds the rest.
    localparam int DATA_W          = ENTRY_W - 2;
    localparam int INSTR_LSB       = 0;
    localparam int PC_LSB          = 64;
    localparam int PC_W            = 30;
    localparam int PRED_LSB        = 94;
    localparam int FAULT_FETCH_BIT = 96;
    localparam int FAULT_PAGE_BIT  = 97;

    function automatic logic [DATA_W-1:0] pack_entry(
        input logic [63:0]     instr,
        input logic [PC_W-1:0] pc_hi,
        input logic [1:0]      pred,
        input logic            fault_fetch,
        input logic            fault_page
    );
        return {fault_page, fault_fetch, pred, pc_hi, instr};
    endfunction

    // Slot 0 is dropped after an odd-word redirect.
    // Slot 1 is dropped behind a taken or faulting slot 0.
    function automatic logic [1:0] slot_valid(
        input logic skip,
        input logic pred0,
        input logic fault
    );
        logic v0;
        v0 = !skip;
        return {!(v0 && (pred0 || fault)), v0};
    endfunction

endpackage

// File: rtl/biriscv_inst_queue_ram.sv
// biriscv_inst_queue_ram: DEPTH x entry register array, one write port, one async read port
module biriscv_inst_queue_ram
    import biriscv_inst_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = DATA_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Payload needs no reset: validity is tracked by the queue's slot_v array.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/biriscv_inst_queue.sv
// biriscv_inst_queue: fetch packet queue presenting the head entry as two in-order issue lanes
module biriscv_inst_queue
    import biriscv_inst_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_request_i,
    input  logic [31:0] branch_pc_i,
    input  logic        fetch_valid_i,
    input  logic [63:0] fetch_instr_i,
    input  logic [31:0] fetch_pc_i,
    input  logic [1:0]  fetch_pred_branch_i,
    input  logic        fetch_fault_fetch_i,
    input  logic        fetch_fault_page_i,
    output logic        fetch_accept_o,
    output logic        lane0_valid_o,
    output logic [31:0] lane0_instr_o,
    output logic [31:0] lane0_pc_o,
    output logic        lane0_pred_o,
    output logic        lane0_fault_fetch_o,
    output logic        lane0_fault_page_o,
    input  logic        lane0_accept_i,
    output logic        lane1_valid_o,
    output logic [31:0] lane1_instr_o,
    output logic [31:0] lane1_pc_o,
    output logic        lane1_pred_o,
    output logic        lane1_fault_fetch_o,
    output logic        lane1_fault_page_o,
    input  logic        lane1_accept_i
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       count_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [1:0]        slot_v_q [DEPTH];
    logic              skip_q;
    logic              push;
    logic              pop_lane0;
    logic              pop_all;
    logic              pop_half;
    logic [1:0]        new_v;
    logic [1:0]        head_v;
    logic [DATA_W-1:0] head;
    logic              sel1;
    logic [31:0]       pc_base;
    logic [31:0]       slot0;
    logic [31:0]       slot1;
    logic              unused;

    // Packets are 8-byte aligned and a redirect only selects the word within one.
    assign unused = ^{fetch_pc_i[1:0], branch_pc_i[31:3], branch_pc_i[1:0]};

    assign fetch_accept_o = count_q != (AW+1)'(DEPTH);
    assign push           = fetch_valid_i && fetch_accept_o && !branch_request_i;
    assign new_v          = slot_valid(skip_q, fetch_pred_branch_i[0], fetch_fault_fetch_i | fetch_fault_page_i);

    biriscv_inst_queue_ram #(.DEPTH(DEPTH), .W(DATA_W)) u_ram (
        .clk_i   (clk_i),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (pack_entry(fetch_instr_i, fetch_pc_i[31:2], fetch_pred_branch_i, fetch_fault_fetch_i, fetch_fault_page_i)),
        .rd_addr (rd_ptr_q),
        .rd_data (head)
    );

    assign head_v  = (count_q != '0) ? slot_v_q[rd_ptr_q] : 2'b00;
    assign sel1    = !head_v[0];
    assign pc_base = {head[PC_LSB +: PC_W], 2'b00};
    assign slot0   = head[INSTR_LSB +: 32];
    assign slot1   = head[INSTR_LSB + 32 +: 32];

    // Lane 0 shows the oldest live slot; lane 1 only exists when both slots are live.
    assign lane0_valid_o       = |head_v;
    assign lane0_instr_o       = lane0_valid_o ? (sel1 ? slot1 : slot0) : '0;
    assign lane0_pc_o          = lane0_valid_o ? (sel1 ? pc_base + 32'd4 : pc_base) : '0;
    assign lane0_pred_o        = lane0_valid_o && (sel1 ? head[PRED_LSB + 1] : head[PRED_LSB]);
    assign lane0_fault_fetch_o = lane0_valid_o && head[FAULT_FETCH_BIT];
    assign lane0_fault_page_o  = lane0_valid_o && head[FAULT_PAGE_BIT];
    assign lane1_valid_o       = &head_v;
    assign lane1_instr_o       = lane1_valid_o ? slot1 : '0;
    assign lane1_pc_o          = lane1_valid_o ? pc_base + 32'd4 : '0;
    assign lane1_pred_o        = lane1_valid_o && head[PRED_LSB + 1];
    assign lane1_fault_fetch_o = lane1_valid_o && head[FAULT_FETCH_BIT];
    assign lane1_fault_page_o  = lane1_valid_o && head[FAULT_PAGE_BIT];

    assign pop_lane0 = lane0_valid_o && lane0_accept_i;
    assign pop_all   = pop_lane0 && (!lane1_valid_o || lane1_accept_i);
    assign pop_half  = pop_lane0 && lane1_valid_o && !lane1_accept_i;

    // Queue bookkeeping: flush beats push/pop; a lane-0-only pop retires slot 0 in place.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            skip_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) slot_v_q[i] <= '0;
        end else if (branch_request_i) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            skip_q   <= branch_pc_i[2];
            for (int i = 0; i < DEPTH; i++) slot_v_q[i] <= '0;
        end else begin
            if (pop_all) begin
                slot_v_q[rd_ptr_q] <= '0;
                rd_ptr_q           <= rd_ptr_q + 1'b1;
            end
            if (pop_half) slot_v_q[rd_ptr_q][0] <= 1'b0;
            if (push) begin
                slot_v_q[wr_ptr_q] <= new_v;
                wr_ptr_q           <= wr_ptr_q + 1'b1;
                skip_q             <= 1'b0;
            end
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop_all);
        end
    end

endmodule

// File: tb/tb_biriscv_inst_queue.sv
// tb_biriscv_inst_queue: directed self-checking bench for the instruction queue
module tb_biriscv_inst_queue;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        branch_request_i;
    logic [31:0] branch_pc_i;
    logic        fetch_valid_i;
    logic [63:0] fetch_instr_i;
    logic [31:0] fetch_pc_i;
    logic [1:0]  fetch_pred_branch_i;
    logic        fetch_fault_fetch_i;
    logic        fetch_fault_page_i;
    logic        fetch_accept_o;
    logic        lane0_valid_o, lane0_pred_o, lane0_fault_fetch_o, lane0_fault_page_o, lane0_accept_i;
    logic [31:0] lane0_instr_o, lane0_pc_o;
    logic        lane1_valid_o, lane1_pred_o, lane1_fault_fetch_o, lane1_fault_page_o, lane1_accept_i;
    logic [31:0] lane1_instr_o, lane1_pc_o;

    int compared = 0;
    int mismatched = 0;

    biriscv_inst_queue dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .branch_request_i    (branch_request_i),
        .branch_pc_i         (branch_pc_i),
        .fetch_valid_i       (fetch_valid_i),
        .fetch_instr_i       (fetch_instr_i),
        .fetch_pc_i          (fetch_pc_i),
        .fetch_pred_branch_i (fetch_pred_branch_i),
        .fetch_fault_fetch_i (fetch_fault_fetch_i),
        .fetch_fault_page_i  (fetch_fault_page_i),
        .fetch_accept_o      (fetch_accept_o),
        .lane0_valid_o       (lane0_valid_o),
        .lane0_instr_o       (lane0_instr_o),
        .lane0_pc_o          (lane0_pc_o),
        .lane0_pred_o        (lane0_pred_o),
        .lane0_fault_fetch_o (lane0_fault_fetch_o),
        .lane0_fault_page_o  (lane0_fault_page_o),
        .lane0_accept_i      (lane0_accept_i),
        .lane1_valid_o       (lane1_valid_o),
        .lane1_instr_o       (lane1_instr_o),
        .lane1_pc_o          (lane1_pc_o),
        .lane1_pred_o        (lane1_pred_o),
        .lane1_fault_fetch_o (lane1_fault_fetch_o),
        .lane1_fault_page_o  (lane1_fault_page_o),
        .lane1_accept_i      (lane1_accept_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic lanes(input string tag, input logic v0, input logic [31:0] i0, input logic [31:0] pc0,
                         input logic p0, input logic v1, input logic [31:0] i1, input logic [31:0] pc1);
        chk({tag, ".v0"}, 32'(lane0_valid_o), 32'(v0));
        chk({tag, ".i0"}, lane0_instr_o, i0);
        chk({tag, ".pc0"}, lane0_pc_o, pc0);
        chk({tag, ".p0"}, 32'(lane0_pred_o), 32'(p0));
        chk({tag, ".v1"}, 32'(lane1_valid_o), 32'(v1));
        chk({tag, ".i1"}, lane1_instr_o, i1);
        chk({tag, ".pc1"}, lane1_pc_o, pc1);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".v0"}, 32'(lane0_valid_o), 32'd0);
        chk({tag, ".v1"}, 32'(lane1_valid_o), 32'd0);
        chk({tag, ".acc"}, 32'(fetch_accept_o), 32'd1);
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic idle;
        branch_request_i    = 1'b0;
        branch_pc_i         = '0;
        fetch_valid_i       = 1'b0;
        fetch_instr_i       = '0;
        fetch_pc_i          = '0;
        fetch_pred_branch_i = '0;
        fetch_fault_fetch_i = 1'b0;
        fetch_fault_page_i  = 1'b0;
        lane0_accept_i      = 1'b0;
        lane1_accept_i      = 1'b0;
    endtask

    task automatic push(input logic [63:0] instr, input logic [31:0] pc, input logic [1:0] pred,
                        input logic ff, input logic fp);
        fetch_valid_i       = 1'b1;
        fetch_instr_i       = instr;
        fetch_pc_i          = pc;
        fetch_pred_branch_i = pred;
        fetch_fault_fetch_i = ff;
        fetch_fault_page_i  = fp;
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        #1;
        chk_empty("reset");
        chk("reset.i0", lane0_instr_o, 32'd0);
        chk("reset.pc0", lane0_pc_o, 32'd0);
        step();
        rst_i = 1'b0;

        push(64'h00000013_00100093, 32'h1000, 2'b00, 1'b0, 1'b0);
        step();
        idle();
        lanes("basic", 1, 32'h00100093, 32'h1000, 0, 1, 32'h00000013, 32'h1004);
        lane0_accept_i = 1'b1;
        lane1_accept_i = 1'b1;
        step();
        idle();
        chk_empty("basic.pop");

        branch_request_i = 1'b1;
        branch_pc_i      = 32'h2004;
        step();
        idle();
        push(64'hBBBBBBBB_AAAAAAAA, 32'h2000, 2'b00, 1'b0, 1'b0);
        step();
        push(64'hDDDDDDDD_CCCCCCCC, 32'h2008, 2'b00, 1'b0, 1'b0);
        lanes("skip", 1, 32'hBBBBBBBB, 32'h2004, 0, 0, 32'd0, 32'd0);
        step();
        idle();
        chk("skip.full", 32'(fetch_accept_o), 32'd0);
        lane0_accept_i = 1'b1;
        step();
        idle();
        lanes("skip2", 1, 32'hCCCCCCCC, 32'h2008, 0, 1, 32'hDDDDDDDD, 32'h200C);
        chk("skip2.acc", 32'(fetch_accept_o), 32'd1);
        lane0_accept_i = 1'b1;
        lane1_accept_i = 1'b1;
        step();
        idle();
        chk_empty("skip.pop");

        push(64'h22222222_11111111, 32'h3000, 2'b01, 1'b0, 1'b0);
        step();
        push(64'h44444444_33333333, 32'h3008, 2'b00, 1'b0, 1'b1);
        lanes("pred", 1, 32'h11111111, 32'h3000, 1, 0, 32'd0, 32'd0);
        chk("pred.fp", 32'(lane0_fault_page_o), 32'd0);
        step();
        idle();
        lane0_accept_i = 1'b1;
        step();
        idle();
        lanes("fault", 1, 32'h33333333, 32'h3008, 0, 0, 32'd0, 32'd0);
        chk("fault.fp", 32'(lane0_fault_page_o), 32'd1);
        chk("fault.ff", 32'(lane0_fault_fetch_o), 32'd0);
        lane0_accept_i = 1'b1;
        step();
        idle();
        chk_empty("fault.pop");

        push(64'h66666666_55555555, 32'h4000, 2'b10, 1'b0, 1'b0);
        step();
        idle();
        lanes("part", 1, 32'h55555555, 32'h4000, 0, 1, 32'h66666666, 32'h4004);
        chk("part.p1", 32'(lane1_pred_o), 32'd1);
        lane0_accept_i = 1'b1;
        step();
        idle();
        lanes("half", 1, 32'h66666666, 32'h4004, 1, 0, 32'd0, 32'd0);
        lane1_accept_i = 1'b1;
        step();
        idle();
        lanes("l1only", 1, 32'h66666666, 32'h4004, 1, 0, 32'd0, 32'd0);
        lane0_accept_i = 1'b1;
        step();
        idle();
        chk_empty("part.pop");

        push(64'hA1A1A1A1_A0A0A0A0, 32'h5000, 2'b00, 1'b0, 1'b0);
        step();
        push(64'hB1B1B1B1_B0B0B0B0, 32'h5008, 2'b00, 1'b0, 1'b0);
        step();
        push(64'hC1C1C1C1_C0C0C0C0, 32'h5010, 2'b00, 1'b0, 1'b0);
        chk("full.acc", 32'(fetch_accept_o), 32'd0);
        step();
        idle();
        lanes("full.head", 1, 32'hA0A0A0A0, 32'h5000, 0, 1, 32'hA1A1A1A1, 32'h5004);
        lane0_accept_i = 1'b1;
        step();
        idle();
        chk("full.halfacc", 32'(fetch_accept_o), 32'd0);
        lanes("full.half", 1, 32'hA1A1A1A1, 32'h5004, 0, 0, 32'd0, 32'd0);
        lane0_accept_i = 1'b1;
        step();
        idle();
        chk("full.popacc", 32'(fetch_accept_o), 32'd1);
        lanes("full.b", 1, 32'hB0B0B0B0, 32'h5008, 0, 1, 32'hB1B1B1B1, 32'h500C);
        lane0_accept_i = 1'b1;
        lane1_accept_i = 1'b1;
        step();
        idle();
        chk_empty("full.nocap");

        for (int i = 0; i <= 6; i++) begin
            idle();
            if (i > 0)
                lanes($sformatf("stream%0d", i), 1, 32'(256 + 2 * (i - 1)), 32'(24576 + 8 * (i - 1)), 0,
                      1, 32'(257 + 2 * (i - 1)), 32'(24580 + 8 * (i - 1)));
            if (i < 6) push({32'(257 + 2 * i), 32'(256 + 2 * i)}, 32'(24576 + 8 * i), 2'b00, 1'b0, 1'b0);
            lane0_accept_i = i > 0;
            lane1_accept_i = i > 0;
            step();
        end
        idle();
        chk_empty("stream.end");

        push(64'hE1E1E1E1_E0E0E0E0, 32'h7000, 2'b00, 1'b0, 1'b0);
        step();
        push(64'hE3E3E3E3_E2E2E2E2, 32'h7008, 2'b00, 1'b0, 1'b0);
        step();
        push(64'hE5E5E5E5_E4E4E4E4, 32'h7010, 2'b00, 1'b0, 1'b0);
        branch_request_i = 1'b1;
        branch_pc_i      = 32'h7000;
        lane0_accept_i   = 1'b1;
        lane1_accept_i   = 1'b1;
        step();
        idle();
        chk_empty("flush");
        push(64'hF1F1F1F1_F0F0F0F0, 32'h8000, 2'b00, 1'b0, 1'b0);
        step();
        idle();
        lanes("postflush", 1, 32'hF0F0F0F0, 32'h8000, 0, 1, 32'hF1F1F1F1, 32'h8004);

        #3;
        rst_i = 1'b1;
        #1;
        chk_empty("arst");
        chk("arst.i0", lane0_instr_o, 32'd0);
        chk("arst.pc0", lane0_pc_o, 32'd0);
        step();
        rst_i = 1'b0;
        step();
        chk_empty("arst.after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/biriscv_inst_queue.md
# biriscv_inst_queue

Instruction queue between `biriscv_fetch` and the decode/issue stage. It buffers 64-bit fetch packets, each holding two 32-bit instruction slots, and tracks per-slot validity. Validity comes from branch-target alignment, predicted-taken branches and fetch faults. The head entry is presented as up to two in-order issue lanes, and the queue supports partial (lane-0-only) consumption and flush on branch redirect.

## Interface
Parameters:
- `DEPTH`, 2: number of packet entries; power of two, ≥2.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk_i` in 1: clock.
  - `rst_i` in 1: reset.
- Flush / redirect:
  - `branch_request_i` in 1: redirect, flushes the queue.
  - `branch_pc_i` in 32: redirect target; only bit 2 is used.
- Push side (from fetch):
  - `fetch_valid_i` in 1: packet valid.
  - `fetch_instr_i` in 64: [31:0] slot0, [63:32] slot1.
  - `fetch_pc_i` in 32: packet PC, 8-byte aligned.
  - `fetch_pred_branch_i` in 2: bit n set means slot n is predicted taken.
  - `fetch_fault_fetch_i` in 1: bus error.
  - `fetch_fault_page_i` in 1: page fault.
  - `fetch_accept_o` out 1: queue not full.
- Issue lane 0:
  - `lane0_valid_o` out 1
  - `lane0_instr_o` out 32
  - `lane0_pc_o` out 32
  - `lane0_pred_o` out 1
  - `lane0_fault_fetch_o` out 1
  - `lane0_fault_page_o` out 1
  - `lane0_accept_i` in 1
- Issue lane 1: same signal set as lane 0 with `lane1_` prefix.

## Operation
- Entry state: packet fields plus `slot_v[1:0]`.
  - `slot_v` is computed at push; an entry with `slot_v == 0` is never written.
- Skip flag `skip_q`:
  - Set on `branch_request_i` to `branch_pc_i[2]`.
  - Cleared by the first successful push after the redirect.
- Slot validity at push:
  - slot0 valid = !`skip_q`.
  - slot1 valid = !(slot0 valid && (`pred[0]` || fault)).
  - A fault packet therefore delivers exactly one valid slot, carrying the fault flags.
  - An entry whose `slot_v` computes to 0 does not occur.
- Push:
  - Occurs when `fetch_valid_i && fetch_accept_o && !branch_request_i`.
  - `fetch_accept_o` = (count != DEPTH), from registered state only; same-cycle pop does not raise it.
- Lane mapping (head entry only, no merging across entries):
  - If `slot_v[0]`: lane0 = slot0 (pc), lane1 = slot1 (pc+4) when `slot_v[1]`.
  - Otherwise lane0 = slot1 (pc+4), and lane1 is invalid.
  - Lane pred = the `pred` bit of the mapped slot.
- Pop:
  - `lane1_accept_i` is honoured only together with `lane0_accept_i`; `lane1_accept_i` alone is ignored.
  - Accept of all valid lanes frees the head entry.
  - Accept of lane0 only while lane1 is valid clears `slot_v[0]` of the head; the entry remains.
- Push and pop in the same cycle are both performed; count is unchanged when one entry is freed.
- Flush: `branch_request_i` clears all entries and pointers next cycle. Same-cycle push and pop are discarded.
- Wrap-around: read and write pointers are `log2(DEPTH)` bits and wrap naturally; count is `log2(DEPTH)+1` bits.

## Timing
- Reset values:
  - Queue empty, `skip_q`=0.
  - `fetch_accept_o`=1.
  - All `laneN_valid_o`=0; lane data outputs 0.
- Latency: a packet pushed in cycle N is visible on the lanes in cycle N+1 (outputs are a combinational mux of the head entry).
- The lanes have no combinational path from the `fetch_*` inputs. `fetch_accept_o` has no combinational path from any input.
- Reset asserted mid-operation empties the queue asynchronously. Outputs go to reset values immediately.
- Lane outputs are held stable while valid and not accepted.

## Structure
- Shared package:
  - Entry width constant (100 bits incl. `slot_v`).
  - Field offsets: instr, pc, pred, faults.
- Sub-module `biriscv_inst_queue_ram`: DEPTH×entry register array with one write port and one read port.
  - It sits beside a `slot_v` array that is kept separately, because the lane-0-only pop updates `slot_v` in place.

## Test plan
- Basic flow: push instr=0x00000013_00100093 @ pc 0x1000, pred=0.
  - Cycle+1: lane0 0x00100093 @0x1000 and lane1 0x00000013 @0x1004 are both valid.
  - Accept both: queue empty.
- Redirect to 0x2004, then push packet @0x2000:
  - Only lane0 is valid, showing slot1 @0x2004.
  - A second packet @0x2008 presents both slots.
- Predicted taken: `pred`=2'b01 @0x3000 gives lane0 valid with pred=1 and lane1 invalid. A fault packet gives a single lane with the fault flag.
- Partial pop: accept lane0 only.
  - Next cycle, lane0 = former slot1 @pc+4, lane1 invalid, and count is unchanged until that lane is accepted.
- Full/backpressure (DEPTH=2):
  - Push two packets with no accepts: `fetch_accept_o`=0, and a third `fetch_valid_i` is not captured.
  - Pop one: `fetch_accept_o`=1 next cycle.
  - Continuous streaming across pointer wrap preserves order.
- Flush with simultaneous push and pop on a full queue:
  - Next cycle the queue is empty and `fetch_accept_o`=1.
  - Asynchronous `rst_i` pulse mid-stream: outputs are 0 immediately.
